// File: rtl/jtframe_db9_pkg.sv
// jtframe_db9_pkg: shared types and constants for the DB9 Sega pad reader.
package jtframe_db9_pkg;

  // Scan sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  // Bit positions inside the 12-bit jtframe button word
  localparam int BTN_R     = 0;
  localparam int BTN_L     = 1;
  localparam int BTN_D     = 2;
  localparam int BTN_U     = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_X     = 7;
  localparam int BTN_Y     = 8;
  localparam int BTN_Z     = 9;
  localparam int BTN_START = 10;
  localparam int BTN_MODE  = 11;

  // Select phases that carry useful data
  localparam logic [2:0] PH_DIR = 3'd0;  // select high: U D L R B C
  localparam logic [2:0] PH_AS  = 3'd1;  // select low: A and Start
  localparam logic [2:0] PH_ID  = 3'd5;  // select low: 6-button signature
  localparam logic [2:0] PH_XYZ = 3'd6;  // select high: Z Y X Mode

  // Buttons feeding the hot-key combos, one bundle per port
  typedef struct packed {
    logic start;
    logic a;
    logic x;
  } btn_hot_t;

  // A 6-button pad pulls all four direction pins low on the third low phase
  function automatic logic dirs_all_low(input logic [3:0] raw_dirs);
    return ~|raw_dirs;
  endfunction

endpackage

// File: rtl/jtframe_db9_decode.sv
// jtframe_db9_decode: per-port capture and decode of one DB9 Sega pad.
// Optional macro JTFRAME_DB9_DEBOUNCE_EN: a word bit commits only when the
// last two scans agree on it.
module jtframe_db9_decode
  import jtframe_db9_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [5:0]  pins,      // synchronised {pin9, pin6, right, left, down, up}, active-low
  input  logic        capture,   // last cycle of the current select phase
  input  logic [2:0]  phase,
  input  logic        commit,    // end of scan: publish the word
  output logic [11:0] word,
  output logic        six_btn,
  output btn_hot_t    hot_next   // combo buttons of the word about to be committed
);

  logic [5:0]  act;
  logic        up, down, left, right, b, c, a, start;
  logic        id, z, y, x, mode;
  logic [11:0] scan_word;
  logic [11:0] word_next;

  assign act = ~pins;

  // Latch the pins belonging to each meaningful phase of the scan
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      up <= 1'b0; down <= 1'b0; left <= 1'b0; right <= 1'b0;
      b  <= 1'b0; c    <= 1'b0; a    <= 1'b0; start <= 1'b0;
      id <= 1'b0; z    <= 1'b0; y    <= 1'b0; x     <= 1'b0; mode <= 1'b0;
    end else if (capture) begin
      case (phase)
        PH_DIR: begin
          up    <= act[0];
          down  <= act[1];
          left  <= act[2];
          right <= act[3];
          b     <= act[4];
          c     <= act[5];
        end
        PH_AS: begin
          a     <= act[4];
          start <= act[5];
        end
        PH_ID: id <= dirs_all_low(pins[3:0]);
        PH_XYZ: begin
          z    <= act[0];
          y    <= act[1];
          x    <= act[2];
          mode <= act[3];
        end
        default: ;  // phases 2, 3, 4 and 7 carry nothing we use
      endcase
    end
  end

  // Assemble the scanned word; extra buttons only count on a 6-button pad
  always_comb begin
    scan_word            = '0;
    scan_word[BTN_R]     = right;
    scan_word[BTN_L]     = left;
    scan_word[BTN_D]     = down;
    scan_word[BTN_U]     = up;
    scan_word[BTN_A]     = a;
    scan_word[BTN_B]     = b;
    scan_word[BTN_C]     = c;
    scan_word[BTN_START] = start;
    if (id) begin
      scan_word[BTN_X]    = x;
      scan_word[BTN_Y]    = y;
      scan_word[BTN_Z]    = z;
      scan_word[BTN_MODE] = mode;
    end
  end

`ifdef JTFRAME_DB9_DEBOUNCE_EN
  logic [11:0] prev_scan;
  logic [11:0] agree;

  assign agree     = ~(scan_word ^ prev_scan);
  assign word_next = (scan_word & agree) | (word & ~agree);

  // Remember the previous scan so each bit needs two matching scans
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset)       prev_scan <= '0;
    else if (commit) prev_scan <= scan_word;
  end
`else
  assign word_next = scan_word;
`endif

  assign hot_next.start = word_next[BTN_START];
  assign hot_next.a     = word_next[BTN_A];
  assign hot_next.x     = word_next[BTN_X];

  // Publish the word and pad type together at the end of the scan
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      word    <= '0;
      six_btn <= 1'b0;
    end else if (commit) begin
      word    <= word_next;
      six_btn <= id;
    end
  end

endmodule

// File: rtl/jtframe_db9_joy.sv
// jtframe_db9_joy: N-port DB9 Sega pad reader with 3/6-button auto-detection,
// OSD request and scan-doubler toggle hot-keys.
// Optional macro JTFRAME_DB9_DEBOUNCE_EN enables per-bit debounce in the
// per-port decoders.
module jtframe_db9_joy
  import jtframe_db9_pkg::*;
#(
  parameter int CLK_KHZ    = 50000,
  parameter int NJOY       = 2,
  parameter int PHASE_US   = 20,
  parameter int IDLE_US    = 2000,
  parameter int HOLD_SCANS = 4
)(
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [6*NJOY-1:0]  joy_bus,
  output logic               joy_select,
  output logic [12*NJOY-1:0] joystick,
  output logic [NJOY-1:0]    six_btn,
  output logic               scan_valid,
  output logic               osd_en,
  output logic               scan2x_enb
);

  localparam int PHASE_CYC = CLK_KHZ * PHASE_US / 1000;
  localparam int IDLE_CYC  = CLK_KHZ * IDLE_US / 1000;
  localparam int CNT_MAX   = (IDLE_CYC > PHASE_CYC) ? IDLE_CYC : PHASE_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int HOLD_W    = $clog2(HOLD_SCANS + 1);

  localparam logic [CNT_W-1:0]  IDLE_LAST  = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0]  PHASE_LAST = CNT_W'(PHASE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(HOLD_SCANS);

  logic [6*NJOY-1:0] bus_meta, bus_sync;
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        phase;
  logic              phase_end, commit;
  btn_hot_t          hot_next [NJOY];
  logic              any_start, any_a, any_x;
  logic [HOLD_W-1:0] osd_cnt, x_cnt, osd_cnt_next, x_cnt_next;

  // Two-flop synchroniser for the raw pad pins; idle pins read high
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bus_meta <= '1;
      bus_sync <= '1;
    end else begin
      bus_meta <= joy_bus;
      bus_sync <= bus_meta;
    end
  end

  assign phase_end = (state == SCAN) && (cnt == PHASE_LAST);
  assign commit    = phase_end && (phase == 3'd7);

  // Scan sequencer: idle gap, eight select phases, one-cycle publish
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      phase      <= '0;
      joy_select <= 1'b1;
      scan_valid <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      case (state)
        IDLE: begin
          joy_select <= 1'b1;
          if (cnt == IDLE_LAST) begin
            state <= SCAN;
            cnt   <= '0;
            phase <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SCAN: begin
          if (phase_end) begin
            cnt <= '0;
            if (phase == 3'd7) begin
              state      <= UPDATE;
              joy_select <= 1'b1;
              scan_valid <= 1'b1;
            end else begin
              phase      <= phase + 3'd1;
              // next phase is odd exactly when the current one is even
              joy_select <= phase[0];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        UPDATE: begin
          state <= IDLE;
          cnt   <= '0;
          phase <= '0;
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          phase      <= '0;
          joy_select <= 1'b1;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NJOY; gi++) begin : g_port
      jtframe_db9_decode u_decode (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .pins     (bus_sync[6*gi +: 6]),
        .capture  (phase_end),
        .phase    (phase),
        .commit   (commit),
        .word     (joystick[12*gi +: 12]),
        .six_btn  (six_btn[gi]),
        .hot_next (hot_next[gi])
      );
    end
  endgenerate

  // Combos look at the OR of every port's upcoming word
  always_comb begin
    any_start = 1'b0;
    any_a     = 1'b0;
    any_x     = 1'b0;
    for (int p = 0; p < NJOY; p++) begin
      any_start = any_start | hot_next[p].start;
      any_a     = any_a     | hot_next[p].a;
      any_x     = any_x     | hot_next[p].x;
    end
  end

  // Saturating hold counters: climb while the combo is held, clear on release
  always_comb begin
    osd_cnt_next = '0;
    x_cnt_next   = '0;
    if (any_start && any_a)
      osd_cnt_next = (osd_cnt == HOLD_MAX) ? osd_cnt : osd_cnt + 1'b1;
    if (any_start && any_x)
      x_cnt_next = (x_cnt == HOLD_MAX) ? x_cnt : x_cnt + 1'b1;
  end

  // Hot-key outputs update together with the published words
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      osd_cnt    <= '0;
      x_cnt      <= '0;
      osd_en     <= 1'b0;
      scan2x_enb <= 1'b0;
    end else if (commit) begin
      osd_cnt <= osd_cnt_next;
      x_cnt   <= x_cnt_next;
      osd_en  <= (osd_cnt_next == HOLD_MAX);
      // toggle only on the scan that first reaches the hold count
      if (x_cnt_next == HOLD_MAX && x_cnt != HOLD_MAX)
        scan2x_enb <= ~scan2x_enb;
    end
  end

endmodule

// File: tb/tb_jtframe_db9_joy.sv
// tb_jtframe_db9_joy: directed bench for jtframe_db9_joy with behavioural
// 3-button and 6-button pad models on both ports.
`timescale 1ns/1ps
module tb_jtframe_db9_joy;

`ifdef JTFRAME_DB9_DEBOUNCE_EN
  localparam int DB = 1;
`else
  localparam int DB = 0;
`endif

  // Pad button indices (active-high view)
  localparam int R = 0, L = 1, D = 2, U = 3, A = 4, B = 5, C = 6;
  localparam int X = 7, Y = 8, Z = 9, ST = 10, MD = 11;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [11:0] joy_bus = '1;
  logic        joy_select;
  logic [23:0] joystick;
  logic [1:0]  six_btn;
  logic        scan_valid, osd_en, scan2x_enb;

  int n_vec  = 0;
  int n_miss = 0;

  jtframe_db9_joy #(
    .CLK_KHZ(1000), .NJOY(2), .PHASE_US(4), .IDLE_US(20), .HOLD_SCANS(2)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .joy_bus    (joy_bus),
    .joy_select (joy_select),
    .joystick   (joystick),
    .six_btn    (six_btn),
    .scan_valid (scan_valid),
    .osd_en     (osd_en),
    .scan2x_enb (scan2x_enb)
  );

  always #5 clk_sys = ~clk_sys;

  // ---------------- pad model ----------------
  int          pad_type [2];   // 0 none, 1 3-button, 2 6-button
  logic [11:0] pad_btn  [2];
  int          edge_cnt = 0;
  int          hi_run   = 0;
  logic        sel_prev = 1'b1;

  function automatic logic [5:0] pad_pins(input int typ, input logic [11:0] bt,
                                          input int ec, input logic sel);
    logic [5:0] pulled;
    pulled = '0;
    if (typ == 0) return 6'h3F;
    if (sel) begin
      if (typ == 2 && ec == 6) pulled = {bt[C], bt[B], bt[MD], bt[X], bt[Y], bt[Z]};
      else                     pulled = {bt[C], bt[B], bt[R], bt[L], bt[D], bt[U]};
    end else begin
      if (typ == 2 && ec == 5) pulled = {bt[ST], bt[A], 4'hF};
      else                     pulled = {bt[ST], bt[A], 2'b11, bt[D], bt[U]};
    end
    return ~pulled;
  endfunction

  always @(negedge clk_sys) begin
    if (joy_select !== sel_prev) edge_cnt++;
    sel_prev = joy_select;
    if (joy_select) hi_run++; else hi_run = 0;
    if (hi_run >= 8) edge_cnt = 0;
    for (int p = 0; p < 2; p++)
      joy_bus[6*p +: 6] = pad_pins(pad_type[p], pad_btn[p], edge_cnt, joy_select);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sv(output int n);
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!scan_valid && n < 200);
  endtask

  task automatic scans(input int k);
    int n;
    for (int i = 0; i < k; i++) begin
      wait_sv(n);
      chk("scan_valid_seen", {31'd0, scan_valid}, 32'd1);
    end
  endtask

  task automatic set_pad(input int p, input int typ, input logic [11:0] bt);
    pad_type[p] = typ;
    pad_btn[p]  = bt;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int  n;
    logic exp_sel;
    set_pad(0, 0, 12'h000);
    set_pad(1, 0, 12'h000);

    // reset state
    repeat (3) @(negedge clk_sys);
    chk("rst_select",   {31'd0, joy_select}, 32'd1);
    chk("rst_joystick", {8'd0, joystick},    32'd0);
    chk("rst_six_btn",  {30'd0, six_btn},    32'd0);
    chk("rst_valid",    {31'd0, scan_valid}, 32'd0);
    chk("rst_osd",      {31'd0, osd_en},     32'd0);
    chk("rst_scan2x",   {31'd0, scan2x_enb}, 32'd0);
    reset = 1'b0;

    // select waveform and scan_valid over the first scan
    for (int k = 1; k <= 52; k++) begin
      @(negedge clk_sys);
      if (k < 24 || k >= 52) exp_sel = 1'b1;
      else                   exp_sel = (((k - 20) / 4) % 2) == 0;
      chk($sformatf("select_k%0d", k), {31'd0, joy_select}, {31'd0, exp_sel});
      chk($sformatf("valid_k%0d", k),  {31'd0, scan_valid}, {31'd0, (k == 52)});
    end
    chk("unplugged_word", {8'd0, joystick}, 32'd0);
    chk("unplugged_six",  {30'd0, six_btn}, 32'd0);
    wait_sv(n);
    chk("scan_period", n, 32'd53);

    // 3-button pad on port0: B, C, Right
    #2 set_pad(0, 1, 12'h061);
    scans(1 + DB);
    chk("p0_3btn_word", {20'd0, joystick[11:0]},  32'h061);
    chk("p1_empty_word", {20'd0, joystick[23:12]}, 32'h000);
    chk("3btn_six",     {30'd0, six_btn},         32'd0);

    // 6-button pad on port1: X, Mode; port0 unplugged
    #2 set_pad(0, 0, 12'h000); set_pad(1, 2, 12'h880);
    scans(1 + DB);
    chk("p1_6btn_word", {20'd0, joystick[23:12]}, 32'h880);
    chk("p0_unplugged", {20'd0, joystick[11:0]},  32'h000);
    chk("6btn_six",     {30'd0, six_btn},         32'd2);

    // OSD combo Start+A on port0
    #2 set_pad(1, 0, 12'h000); set_pad(0, 1, 12'h410);
    scans(1 + DB);
    chk("osd_word",     {20'd0, joystick[11:0]}, 32'h410);
    chk("osd_1st",      {31'd0, osd_en},         32'd0);
    scans(1);
    chk("osd_2nd",      {31'd0, osd_en},         32'd1);
    scans(1);
    chk("osd_3rd",      {31'd0, osd_en},         32'd1);
    #2 set_pad(0, 1, 12'h000);
    scans(1 + DB);
    chk("osd_release",  {31'd0, osd_en},         32'd0);

    // OSD combo split across ports: Start on port0, A on port1
    #2 set_pad(0, 1, 12'h400); set_pad(1, 1, 12'h010);
    scans(1 + DB);
    chk("osd_x_1st",    {31'd0, osd_en},         32'd0);
    scans(1);
    chk("osd_x_2nd",    {31'd0, osd_en},         32'd1);
    #2 set_pad(0, 0, 12'h000); set_pad(1, 0, 12'h000);
    scans(1 + DB);
    chk("osd_x_release", {31'd0, osd_en},        32'd0);

    // scan-doubler combo Start+X on a 6-button pad, held 5 scans
    #2 set_pad(1, 2, 12'h480);
    scans(1 + DB);
    chk("s2x_1st",      {31'd0, scan2x_enb},     32'd0);
    scans(1);
    chk("s2x_2nd",      {31'd0, scan2x_enb},     32'd1);
    for (int i = 3; i <= 5; i++) begin
      scans(1);
      chk($sformatf("s2x_hold%0d", i), {31'd0, scan2x_enb}, 32'd1);
    end
    #2 set_pad(1, 2, 12'h000);
    scans(1 + DB);
    chk("s2x_release",  {31'd0, scan2x_enb},     32'd1);
    #2 set_pad(1, 2, 12'h480);
    scans(1 + DB);
    chk("s2x_again_1",  {31'd0, scan2x_enb},     32'd1);
    scans(1);
    chk("s2x_again_2",  {31'd0, scan2x_enb},     32'd0);
    #2 set_pad(1, 0, 12'h000);
    scans(2);

`ifdef JTFRAME_DB9_DEBOUNCE_EN
    // Up for a single scan is filtered; held two scans it passes
    #2 set_pad(0, 1, 12'h008);
    scans(1);
    chk("db_single_1",  {20'd0, joystick[11:0]}, 32'h000);
    #2 set_pad(0, 1, 12'h000);
    scans(1);
    chk("db_single_2",  {20'd0, joystick[11:0]}, 32'h000);
    #2 set_pad(0, 1, 12'h008);
    scans(1);
    chk("db_held_1",    {20'd0, joystick[11:0]}, 32'h000);
    scans(1);
    chk("db_held_2",    {20'd0, joystick[11:0]}, 32'h008);
    #2 set_pad(0, 0, 12'h000);
    scans(2);
`endif

    // reset during phase 3 of a scan
    #2 set_pad(0, 1, 12'h061); set_pad(1, 2, 12'h000);
    scans(1 + DB);
    chk("pre_rst_word", {20'd0, joystick[11:0]}, 32'h061);
    chk("pre_rst_six",  {30'd0, six_btn},        32'd2);
    repeat (35) @(negedge clk_sys);
    chk("ph3_select",   {31'd0, joy_select},     32'd0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_select",   {31'd0, joy_select}, 32'd1);
    chk("mid_rst_joystick", {8'd0, joystick},    32'd0);
    chk("mid_rst_six",      {30'd0, six_btn},    32'd0);
    chk("mid_rst_valid",    {31'd0, scan_valid}, 32'd0);
    @(negedge clk_sys);
    reset = 1'b0;
    wait_sv(n);
    chk("post_rst_period", n, 32'd52);
    chk("post_rst_six",    {30'd0, six_btn}, 32'd2);
    scans(DB);
    chk("post_rst_word",   {20'd0, joystick[11:0]}, 32'h061);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/jtframe_db9_joy.md
Name: jtframe_db9_joy

Overview:
- Native N-port DB9 Sega pad reader with no external HID core; replaces the fixed 2-port, 50 MHz joystick path.
- Drives the shared select line through the full 8-phase Megadrive protocol and auto-detects 3-button vs 6-button pads per port.
- Publishes active-high 12-bit jtframe button words per port.
- Derives an OSD request and a scan-doubler toggle from hold-qualified button combos.

Parameters:
- CLK_KHZ, 50000, clk_sys frequency in kHz.
- NJOY, 2, number of DB9 ports (1..4).
- PHASE_US, 20, duration of each select phase in µs. PHASE_CYC = CLK_KHZ*PHASE_US/1000 must be ≥ 4.
- IDLE_US, 2000, select-high gap between scans in µs, so the pad's 6-button counter resets. IDLE_CYC = CLK_KHZ*IDLE_US/1000.
- HOLD_SCANS, 4, consecutive scans a combo must be seen before it takes effect.

Ports:
- clk_sys, in, 1, system clock; the only clock.
- reset, in, 1, asynchronous, active-high.
- joy_bus, in, 6*NJOY, raw pins, active-low. Per port p, bits [6p+5:6p] = {pin9, pin6, right, left, down, up}.
- joy_select, out, 1, DB9 pin7 strobe shared by all ports.
- joystick, out, 12*NJOY, per-port word, active-high. Bit map: 0 R, 1 L, 2 D, 3 U, 4 A, 5 B, 6 C, 7 X, 8 Y, 9 Z, 10 Start, 11 Mode.
- six_btn, out, NJOY, pad identified as 6-button on the last scan.
- scan_valid, out, 1, one-cycle pulse when joystick/six_btn update.
- osd_en, out, 1, Start+A held on any port.
- scan2x_enb, out, 1, scan-doubler enable, toggled by Start+X.

Behaviour:
- Reset: joy_select=1, joystick=0, six_btn=0, scan_valid=0, osd_en=0, scan2x_enb=0, FSM=IDLE, all counters 0. Reset mid-scan abandons the partial scan; no output change except the reset values.
- joy_bus passes through a 2-flop synchroniser.
- FSM:
  - IDLE: select=1 for IDLE_CYC cycles, then go to SCAN with phase=0.
  - SCAN: phase 0..7, each PHASE_CYC cycles; joy_select = ~phase[0]. The synchronised bus is captured on the last cycle of each phase. After phase 7, go to UPDATE.
  - UPDATE: 1 cycle; commit all port words and six_btn at once; scan_valid=1. Then go to IDLE.
- Scan period = IDLE_CYC + 8*PHASE_CYC + 1 cycles.
- Per-port decode (inverted pins):
  - Phase 0 (select high): U D L R B C.
  - Phase 1 (select low): A = pin6, Start = pin9.
  - Phase 5 (select low): up/down/left/right raw all low means six_btn=1.
  - Phase 6, only if six_btn: Z = up, Y = down, X = left, Mode = right.
  - Without six_btn, X/Y/Z/Mode = 0.
  - Phases 2, 3, 4 and 7 are captured but ignored.
- No pad fitted: all pins high, so the word is 0 and six_btn is 0.
- Combos are evaluated on OR of all port words, once per UPDATE:
  - osd combo = bit10 & bit4; x combo = bit10 & bit7.
  - A saturating hold counter per combo (width clog2(HOLD_SCANS+1)) increments when the combo is present and clears when absent.
  - osd_en = (osd_cnt == HOLD_SCANS). It rises on the UPDATE where the count reaches HOLD_SCANS and falls on the first UPDATE where the combo is absent.
  - scan2x_enb toggles once, on the UPDATE where x_cnt first reaches HOLD_SCANS. It cannot toggle again until the combo is released.
- Combos on different ports count together, since the words are ORed.
- Outputs change only in UPDATE (or on reset).

Optional Feature:
- Macro: JTFRAME_DB9_DEBOUNCE_EN.
- Enabled: each joystick bit commits only when the last two scans agree; otherwise it holds its previous value. six_btn is not debounced. Combo logic sees the debounced words.
- Disabled: words commit directly from the current scan.

Decomposition:
- Package jtframe_db9_pkg holds:
  - state enum {IDLE, SCAN, UPDATE};
  - bit-index localparams BTN_R..BTN_MODE;
  - phase numbers PH_ID=5 and PH_XYZ=6.
- Sub-module jtframe_db9_decode, one per port via generate:
  - inputs: 6-bit synced port, capture strobe, phase, commit;
  - outputs: 12-bit word and six_btn;
  - contains the optional debounce.
- Top holds FSM, timers, synchroniser and combo logic.

Test Plan:
- All tests use CLK_KHZ=1000, PHASE_US=4, IDLE_US=20, HOLD_SCANS=2, NJOY=2, so PHASE_CYC=4 and IDLE_CYC=20.
- Timing: after reset, joy_select high for 20 cycles, then toggles every 4 cycles (0,1,0,1... low on odd phases); scan_valid pulses every 53 cycles; a reset asserted during phase 3 forces select=1 and outputs=0 immediately.
- 3-button model on port0 with B, C, Right pressed: joystick[11:0]=0x061, six_btn=2'b00.
- 6-button model on port1 with X and Mode pressed: joystick[23:12]=0x880, six_btn[1]=1; unplugged port0 stays 0.
- Start+A held on port0: osd_en rises at the 2nd UPDATE; release drops it at the next UPDATE.
- Start+X held for 5 scans: scan2x_enb 0→1 exactly once; release, then hold again for 2 scans: 1→0.
- With JTFRAME_DB9_DEBOUNCE_EN: Up pressed for a single scan gives no output change; held for 2 scans, bit3 sets on the 2nd UPDATE.
